// File: rtl/otter_ecc_pkg.sv
// Shared Hamming(38,32) code for the OTTER data memory: state encoding, code
// geometry and the encode/correct functions used by both the writer and the read-stage checker.
package otter_ecc_pkg;

  localparam int ECC_PBITS    = 6;
  localparam int ECC_CODE_LEN = 38;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_MERGE,
    ST_WRITE
  } ecc_state_t;

  typedef struct packed {
    logic [31:0] data;
    logic        corr;
    logic        uncorr;
  } ecc_res_t;

  // Data bits occupy the non-power-of-two code positions 1..38 in ascending order.
  function automatic logic [ECC_PBITS-1:0] ecc_encode(input logic [31:0] d);
    logic [ECC_PBITS-1:0] p;
    logic [4:0]           j;
    p = '0;
    j = '0;
    for (int pos = 1; pos <= ECC_CODE_LEN; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (d[j]) p = p ^ pos[ECC_PBITS-1:0];
        j = j + 5'd1;
      end
    end
    return p;
  endfunction

  function automatic ecc_res_t ecc_correct(input logic [31:0] d, input logic [ECC_PBITS-1:0] p);
    ecc_res_t             r;
    logic [ECC_PBITS-1:0] syn;
    logic [4:0]           j;
    syn      = ecc_encode(d) ^ p;
    r.data   = d;
    r.corr   = 1'b0;
    r.uncorr = 1'b0;
    j        = '0;
    if (syn > 6'(ECC_CODE_LEN)) r.uncorr = 1'b1;
    else if (syn != '0)         r.corr   = 1'b1;
    // A syndrome naming a parity position never matches here, leaving data untouched.
    for (int pos = 1; pos <= ECC_CODE_LEN; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (pos[ECC_PBITS-1:0] == syn) r.data[j] = ~r.data[j];
        j = j + 5'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/otter_mem_ecc_writer.sv
// ECC write stage: full store writes at N+1, partial store does read/correct/merge/write (MEM_WE at N+3).
// WR_READY only in IDLE; requests seen while busy are ignored and must be held by the requester.
module otter_mem_ecc_writer
  import otter_ecc_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  MEM_CLK,
  input  logic                  MEM_RST_N,
  input  logic                  WR_REQ,
  input  logic [ADDR_WIDTH-1:0] WR_ADDR,
  input  logic [31:0]           WR_DATA,
  input  logic [3:0]            WR_BE,
  output logic                  WR_READY,
  output logic                  WR_DONE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic                  MEM_RE,
  output logic                  MEM_WE,
  output logic [31:0]           MEM_DIN,
  output logic [ECC_PBITS-1:0]  MEM_PIN,
  input  logic [31:0]           MEM_DOUT,
  input  logic [ECC_PBITS-1:0]  MEM_POUT,
  output logic                  ERR_CORR,
  output logic                  ERR_UNCORR,
  output logic [CNT_WIDTH-1:0]  CE_COUNT
);

  ecc_state_t            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_data;
  logic [3:0]            r_be;
  logic                  r_ready;
  logic                  r_done;
  logic                  r_re;
  logic                  r_we;
  logic [31:0]           r_din;
  logic [ECC_PBITS-1:0]  r_pin;
  logic                  r_corr;
  logic                  r_uncorr;
  logic [CNT_WIDTH-1:0]  r_ce;

  ecc_res_t              w_fix;
  logic [31:0]           w_merged;

  assign w_fix = ecc_correct(MEM_DOUT, MEM_POUT);

  always_comb begin
    w_merged = w_fix.data;
    for (int b = 0; b < 4; b++) begin
      if (r_be[b]) w_merged[8*b +: 8] = r_data[8*b +: 8];
    end
  end

  always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
    if (!MEM_RST_N) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_data   <= '0;
      r_be     <= '0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_re     <= 1'b0;
      r_we     <= 1'b0;
      r_din    <= '0;
      r_pin    <= '0;
      r_corr   <= 1'b0;
      r_uncorr <= 1'b0;
      r_ce     <= '0;
    end else begin
      r_done   <= 1'b0;
      r_re     <= 1'b0;
      r_we     <= 1'b0;
      r_corr   <= 1'b0;
      r_uncorr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (WR_REQ) begin
            r_addr <= WR_ADDR;
            r_data <= WR_DATA;
            r_be   <= WR_BE;
            if (WR_BE == 4'hF) begin
              r_state <= ST_WRITE;
              r_ready <= 1'b0;
              r_we    <= 1'b1;
              r_done  <= 1'b1;
              r_din   <= WR_DATA;
              r_pin   <= ecc_encode(WR_DATA);
            end else if (WR_BE == 4'h0) begin
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_READ;
              r_ready <= 1'b0;
              r_re    <= 1'b1;
            end
          end
        end
        ST_READ: begin
          r_state <= ST_MERGE;
        end
        ST_MERGE: begin
          // Array data for the READ cycle is present now; error pulses ride with the write.
          r_state  <= ST_WRITE;
          r_we     <= 1'b1;
          r_done   <= 1'b1;
          r_din    <= w_merged;
          r_pin    <= ecc_encode(w_merged);
          r_corr   <= w_fix.corr;
          r_uncorr <= w_fix.uncorr;
          if (w_fix.corr && (r_ce != '1)) r_ce <= r_ce + CNT_WIDTH'(1);
        end
        ST_WRITE: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign WR_READY   = r_ready;
  assign WR_DONE    = r_done;
  assign MEM_ADDR   = r_addr;
  assign MEM_RE     = r_re;
  assign MEM_WE     = r_we;
  assign MEM_DIN    = r_din;
  assign MEM_PIN    = r_pin;
  assign ERR_CORR   = r_corr;
  assign ERR_UNCORR = r_uncorr;
  assign CE_COUNT   = r_ce;

endmodule

// File: tb/tb_otter_mem_ecc_writer.sv
// Directed bench for otter_mem_ecc_writer with a transaction-level expectation model and a small array model.
module tb_otter_mem_ecc_writer;

  localparam int AW = 14;
  localparam int CW = 3;
  localparam logic [CW-1:0] CE_MAX = '1;

  logic          MEM_CLK = 1'b0;
  logic          MEM_RST_N = 1'b0;
  logic          WR_REQ = 1'b0;
  logic [AW-1:0] WR_ADDR = '0;
  logic [31:0]   WR_DATA = '0;
  logic [3:0]    WR_BE = '0;
  logic          WR_READY, WR_DONE, MEM_RE, MEM_WE, ERR_CORR, ERR_UNCORR;
  logic [AW-1:0] MEM_ADDR;
  logic [31:0]   MEM_DIN;
  logic [5:0]    MEM_PIN;
  logic [31:0]   MEM_DOUT = '0;
  logic [5:0]    MEM_POUT = '0;
  logic [CW-1:0] CE_COUNT;

  otter_mem_ecc_writer #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .MEM_CLK(MEM_CLK), .MEM_RST_N(MEM_RST_N),
    .WR_REQ(WR_REQ), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_BE(WR_BE),
    .WR_READY(WR_READY), .WR_DONE(WR_DONE),
    .MEM_ADDR(MEM_ADDR), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE),
    .MEM_DIN(MEM_DIN), .MEM_PIN(MEM_PIN), .MEM_DOUT(MEM_DOUT), .MEM_POUT(MEM_POUT),
    .ERR_CORR(ERR_CORR), .ERR_UNCORR(ERR_UNCORR), .CE_COUNT(CE_COUNT)
  );

  always #5 MEM_CLK = ~MEM_CLK;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Array contents plus per-word error injection applied on read.
  logic [31:0] mem_d [64];
  logic [5:0]  mem_p [64];
  logic [31:0] inj_d [64];
  logic [5:0]  inj_p [64];

  always @(posedge MEM_CLK) begin
    #2;
    if (MEM_RE) begin
      MEM_DOUT = mem_d[MEM_ADDR[5:0]] ^ inj_d[MEM_ADDR[5:0]];
      MEM_POUT = mem_p[MEM_ADDR[5:0]] ^ inj_p[MEM_ADDR[5:0]];
    end
    if (MEM_WE) begin
      mem_d[MEM_ADDR[5:0]] = MEM_DIN;
      mem_p[MEM_ADDR[5:0]] = MEM_PIN;
      inj_d[MEM_ADDR[5:0]] = '0;
      inj_p[MEM_ADDR[5:0]] = '0;
    end
  end

  // Code position of data bit i, straight from the bit-placement table.
  function automatic logic [5:0] pos_of(input int i);
    if (i == 0)       return 6'd3;
    else if (i <= 3)  return 6'(i + 4);
    else if (i <= 10) return 6'(i + 5);
    else if (i <= 25) return 6'(i + 6);
    else              return 6'(i + 7);
  endfunction

  function automatic logic [5:0] m_enc(input logic [31:0] d);
    logic [5:0] p = '0;
    for (int i = 0; i < 32; i++) if (d[i]) p ^= pos_of(i);
    return p;
  endfunction

  function automatic logic [5:0] m_syn(input logic [31:0] fd, input logic [5:0] fp);
    logic [5:0] s = '0;
    for (int i = 0; i < 32; i++) if (fd[i]) s ^= pos_of(i);
    for (int k = 0; k < 6; k++) if (fp[k]) s ^= 6'(1 << k);
    return s;
  endfunction

  typedef struct {
    logic          re, we, done, rdy, corr, uncorr;
    logic [AW-1:0] addr;
    logic [31:0]   din;
    logic [5:0]    pin;
  } exp_t;

  exp_t exp_q[$];
  logic [CW-1:0] m_ce = '0;
  logic [31:0]   last_din = '0;
  logic [5:0]    last_pin = '0;

  function automatic exp_t idle_rec();
    exp_t r;
    r.re = 0; r.we = 0; r.done = 0; r.rdy = 1; r.corr = 0; r.uncorr = 0;
    r.addr = '0; r.din = '0; r.pin = '0;
    return r;
  endfunction

  task automatic schedule(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    exp_t r;
    logic [31:0] old, merged;
    logic [5:0]  s;
    if (be == 4'hF) begin
      r = idle_rec(); r.we = 1; r.done = 1; r.rdy = 0; r.addr = a; r.din = d; r.pin = m_enc(d);
      exp_q.push_back(r);
    end else if (be == 4'h0) begin
      r = idle_rec(); r.done = 1;
      exp_q.push_back(r);
    end else begin
      r = idle_rec(); r.re = 1; r.rdy = 0; r.addr = a;
      exp_q.push_back(r);
      r = idle_rec(); r.rdy = 0;
      exp_q.push_back(r);
      r = idle_rec();
      s = m_syn(inj_d[a[5:0]], inj_p[a[5:0]]);
      old = mem_d[a[5:0]] ^ inj_d[a[5:0]];
      if (s >= 6'd1 && s <= 6'd38) begin
        r.corr = 1;
        for (int i = 0; i < 32; i++) if (pos_of(i) == s) old[i] = ~old[i];
      end else if (s > 6'd38) begin
        r.uncorr = 1;
      end
      for (int b = 0; b < 4; b++) merged[8*b +: 8] = be[b] ? d[8*b +: 8] : old[8*b +: 8];
      r.we = 1; r.done = 1; r.rdy = 0; r.addr = a; r.din = merged; r.pin = m_enc(merged);
      exp_q.push_back(r);
    end
  endtask

  always @(negedge MEM_CLK) begin : cmp
    exp_t e;
    e = idle_rec();
    if (!MEM_RST_N) begin
      exp_q.delete();
      m_ce = '0;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end
    if (e.corr && m_ce != CE_MAX) m_ce = m_ce + 1'b1;
    chk("WR_READY", 64'(WR_READY), 64'(e.rdy));
    chk("MEM_RE", 64'(MEM_RE), 64'(e.re));
    chk("MEM_WE", 64'(MEM_WE), 64'(e.we));
    chk("WR_DONE", 64'(WR_DONE), 64'(e.done));
    chk("ERR_CORR", 64'(ERR_CORR), 64'(e.corr));
    chk("ERR_UNCORR", 64'(ERR_UNCORR), 64'(e.uncorr));
    chk("CE_COUNT", 64'(CE_COUNT), 64'(m_ce));
    if (e.re) chk("rd MEM_ADDR", 64'(MEM_ADDR), 64'(e.addr));
    if (e.we) begin
      chk("wr MEM_ADDR", 64'(MEM_ADDR), 64'(e.addr));
      chk("MEM_DIN", 64'(MEM_DIN), 64'(e.din));
      chk("MEM_PIN", 64'(MEM_PIN), 64'(e.pin));
      last_din = MEM_DIN;
      last_pin = MEM_PIN;
    end
    if (MEM_RST_N && WR_REQ && e.rdy) schedule(WR_ADDR, WR_DATA, WR_BE);
  end

  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic do_req(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    int n = 0;
    WR_REQ = 1'b1; WR_ADDR = a; WR_DATA = d; WR_BE = be;
    do begin
      @(negedge MEM_CLK);
      n++;
    end while (!WR_READY && n < 50);
    if (n >= 50) chk("accept timeout", 64'(WR_READY), 64'(1));
    @(posedge MEM_CLK); #1;
  endtask

  task automatic req_off();
    WR_REQ = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge MEM_CLK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_d[i] = '0; mem_p[i] = '0; inj_d[i] = '0; inj_p[i] = '0;
    end
    MEM_RST_N = 1'b0;
    cycles(3);
    MEM_RST_N = 1'b1;

    chk("model enc 1", 64'(m_enc(32'h0000_0001)), 64'(6'b000011));
    chk("model enc ones", 64'(m_enc(32'hFFFF_FFFF)), 64'(6'b011000));
    chk("model syn d0", 64'(m_syn(32'h1, 6'h0)), 64'(6'd3));
    chk("reset CE_COUNT", 64'(CE_COUNT), 64'(0));

    do_req(14'd1, 32'h0000_0001, 4'hF); req_off(); cycles(3);
    chk("full 1 din", 64'(last_din), 64'(32'h0000_0001));
    chk("full 1 pin", 64'(last_pin), 64'(6'b000011));
    do_req(14'd2, 32'hFFFF_FFFF, 4'hF); req_off(); cycles(3);
    chk("full ones pin", 64'(last_pin), 64'(6'b011000));
    do_req(14'd3, 32'h0000_0000, 4'hF); req_off(); cycles(3);
    chk("full zero pin", 64'(last_pin), 64'(6'b000000));

    // Back-to-back: second request is held while the first one writes.
    do_req(14'd5, 32'h1234_5678, 4'hF);
    do_req(14'd5, 32'h0000_AB00, 4'b0010); req_off(); cycles(5);
    chk("merge din", 64'(last_din), 64'(32'h1234_AB78));
    chk("merge CE", 64'(CE_COUNT), 64'(0));

    do_req(14'd6, 32'h1234_5678, 4'hF); req_off(); cycles(3);
    inj_d[6] = 32'h0000_0001;
    do_req(14'd6, 32'h0000_AB00, 4'b0010); req_off(); cycles(5);
    chk("corr d0 din", 64'(last_din), 64'(32'h1234_AB78));
    chk("corr d0 CE", 64'(CE_COUNT), 64'(1));

    do_req(14'd7, 32'hDEAD_BEEF, 4'h0); req_off(); cycles(3);
    chk("be0 mem untouched", 64'(mem_d[7]), 64'(0));

    do_req(14'd10, 32'h0F0F_0F0F, 4'hF); req_off(); cycles(3);
    inj_p[10] = 6'b000100;
    do_req(14'd10, 32'hAA00_00BB, 4'b1001); req_off(); cycles(5);
    chk("corr parity din", 64'(last_din), 64'(32'hAA0F_0FBB));
    chk("corr parity CE", 64'(CE_COUNT), 64'(2));

    do_req(14'd11, 32'hA5A5_A5A5, 4'hF); req_off(); cycles(3);
    inj_d[11] = 32'h0400_0004;
    do_req(14'd11, 32'h0033_0000, 4'b0100); req_off(); cycles(5);
    chk("uncorr raw din", 64'(last_din), 64'(32'hA133_A5A1));
    chk("uncorr CE", 64'(CE_COUNT), 64'(2));

    // Reset while the partial store sits in MERGE: no write may reach the array.
    do_req(14'd12, 32'hCAFE_F00D, 4'hF); req_off(); cycles(3);
    do_req(14'd12, 32'h0000_00EE, 4'b0001); req_off();
    cycles(1);
    MEM_RST_N = 1'b0;
    #2;
    chk("rst MEM_WE", 64'(MEM_WE), 64'(0));
    chk("rst WR_READY", 64'(WR_READY), 64'(1));
    chk("rst CE_COUNT", 64'(CE_COUNT), 64'(0));
    cycles(2);
    MEM_RST_N = 1'b1;
    cycles(3);
    chk("rst no write", 64'(mem_d[12]), 64'(32'hCAFE_F00D));

    for (int i = 0; i < 8; i++) begin
      inj_d[20 + i] = 32'(1) << (i * 4);
      do_req(AW'(20 + i), 32'(i), 4'b0001); req_off(); cycles(5);
    end
    chk("CE saturated", 64'(CE_COUNT), 64'(3'b111));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
